// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
// Contents: receive FSM state enum, frame bit constants and the default
// mid-frame timeout (2 ms at 18.432 MHz).
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic        START_BIT       = 1'b0;
    localparam logic        STOP_BIT        = 1'b1;
    localparam int unsigned DATA_BITS       = 8;
    localparam int unsigned TIMEOUT_CYC_DEF = 36864;

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Bus between the PS/2 receiver and its host (CPU read path / testbench).
// Signals:
//   KB_CLK, KB_DATA   raw PS/2 lines (asynchronous to CLK)
//   RD_STB            one-cycle pulse, pops the FIFO head
//   ERR_CLR           one-cycle pulse, clears the sticky error flags
//   RD_DATA           FIFO head, 0x00 when empty
//   RX_VALID          FIFO not empty
//   OVERRUN, PAR_ERR, FRM_ERR  sticky error flags
// Modports: master drives the lines and strobes, slave is the receiver.
interface ps2_kbd_rx_if;

    logic       KB_CLK;
    logic       KB_DATA;
    logic       RD_STB;
    logic       ERR_CLR;
    logic [7:0] RD_DATA;
    logic       RX_VALID;
    logic       OVERRUN;
    logic       PAR_ERR;
    logic       FRM_ERR;

    modport master (
        output KB_CLK, KB_DATA, RD_STB, ERR_CLR,
        input  RD_DATA, RX_VALID, OVERRUN, PAR_ERR, FRM_ERR
    );

    modport slave (
        input  KB_CLK, KB_DATA, RD_STB, ERR_CLR,
        output RD_DATA, RX_VALID, OVERRUN, PAR_ERR, FRM_ERR
    );

endinterface

// File: rtl/kb_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write request and data (ignored when full unless popping)
//   pop             read request (ignored when empty)
//   head            current head entry, all zeros when empty
//   full, empty     status
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module kb_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop on a full FIFO frees the slot the push lands in on the same edge.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver front-end.
// Synchronises and deglitches KB_CLK/KB_DATA, deframes 11-bit frames
// (start, 8 data LSB first, odd parity, stop), and pushes good bytes into a
// FWFT FIFO whose head is presented on the read bus.
// Ports:
//   CLK   system clock
//   RST   asynchronous active-high reset
//   bus   ps2_kbd_rx_if.slave: PS/2 lines, read/clear strobes, data and flags
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input logic         CLK,
    input logic         RST,
    ps2_kbd_rx_if.slave bus
);

    localparam int unsigned FW  = $clog2(FILT_LEN + 1);
    localparam logic [15:0] TMO = 16'(TIMEOUT_CYC);

    // Index 0 = KB_CLK, index 1 = KB_DATA.
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    filt_q;
    logic [FW-1:0] fcnt_q [2];
    logic          clk_dly_q;
    logic          fall;
    logic          kb_data;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [15:0]   tmo_q, tmo_d;

    logic          push;
    logic          set_par;
    logic          set_frm;
    logic          set_ovr;
    logic          ovr_q, par_err_q, frm_err_q;
    logic          fifo_full;
    logic          fifo_empty;

    // Synchroniser plus saturating filter: a line only changes level after
    // FILT_LEN consecutive samples that disagree with the filtered value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            filt_q    <= 2'b11;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
            clk_dly_q <= 1'b1;
        end else begin
            sync1_q   <= {bus.KB_DATA, bus.KB_CLK};
            sync2_q   <= sync1_q;
            clk_dly_q <= filt_q[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FW'(FILT_LEN - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign fall    = clk_dly_q & ~filt_q[0];
    assign kb_data = filt_q[1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        push      = 1'b0;
        set_par   = 1'b0;
        set_frm   = 1'b0;

        if (state_q == IDLE || fall) tmo_d = '0;
        else                         tmo_d = tmo_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (fall && kb_data == START_BIT) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {kb_data, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = kb_data;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (kb_data != STOP_BIT)            set_frm = 1'b1;
                    else if (!(^{shift_q, par_q}))      set_par = 1'b1;
                    else                                push    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stalled mid-frame: abandon the partial byte.
        if (state_q != IDLE && !fall && tmo_q == TMO) begin
            state_d = IDLE;
            set_frm = 1'b1;
            push    = 1'b0;
            tmo_d   = '0;
        end
    end

    kb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (push),
        .push_data (shift_q),
        .pop       (bus.RD_STB),
        .head      (bus.RD_DATA),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A simultaneous pop makes room, so that push is not an overrun.
    assign set_ovr = push & fifo_full & ~bus.RD_STB;

    // Sticky flags: a set on the same cycle as ERR_CLR wins.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovr_q     <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            ovr_q     <= set_ovr | (ovr_q     & ~bus.ERR_CLR);
            par_err_q <= set_par | (par_err_q & ~bus.ERR_CLR);
            frm_err_q <= set_frm | (frm_err_q & ~bus.ERR_CLR);
        end
    end

    assign bus.RX_VALID = ~fifo_empty;
    assign bus.OVERRUN  = ovr_q;
    assign bus.PAR_ERR  = par_err_q;
    assign bus.FRM_ERR  = frm_err_q;

endmodule
